// File: rtl/bcd_counter_monitor_if.sv
// Signal bundle between a BCD counter's control/outputs and its monitor.
// master: drives the counter copies and observes flags; slave: the monitor itself.
interface bcd_counter_monitor_if;
    logic [3:0] D;
    logic       LOAD;
    logic       ENABLE;
    logic       UP;
    logic [3:0] Q;
    logic       CO;
    logic       ERR_PULSE;
    logic       ERR;
    logic       ILLEGAL;
    logic       CO_ERR;
    logic [3:0] EXP_Q;
    logic [7:0] ERR_CNT;
    logic [7:0] WRAP_CNT;
    logic [1:0] STATE;

    modport master (
        output D, LOAD, ENABLE, UP, Q, CO,
        input  ERR_PULSE, ERR, ILLEGAL, CO_ERR, EXP_Q, ERR_CNT, WRAP_CNT, STATE
    );

    modport slave (
        input  D, LOAD, ENABLE, UP, Q, CO,
        output ERR_PULSE, ERR, ILLEGAL, CO_ERR, EXP_Q, ERR_CNT, WRAP_CNT, STATE
    );
endinterface

// File: rtl/bcd_counter_monitor.sv
// Checks a 1-digit BCD up/down counter against a predicted next digit each cycle.
// Define BCD_MON_CO_CHECK_EN to also check the counter's carry output.
module bcd_counter_monitor (
    input  logic                  CLK,
    input  logic                  CLR,
    bcd_counter_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        StSync  = 2'b00,
        StTrack = 2'b01,
        StFault = 2'b10
    } state_e;

    state_e     r_state, w_state_next;
    logic [3:0] r_exp_q, w_exp_q_next;
    logic       r_exp_wrap, w_exp_wrap_next;
    logic       r_err_pulse, w_err_pulse_next;
    logic       r_err, w_err_next;
    logic       r_illegal, w_illegal_next;
    logic       r_co_err, w_co_err_next;
    logic [7:0] r_err_cnt, w_err_cnt_next;
    logic [7:0] r_wrap_cnt, w_wrap_cnt_next;

    logic w_q_match;
    logic w_q_illegal;
    logic w_co_mismatch;
    logic w_fault;

    assign w_q_match   = (mon.Q == r_exp_q);
    assign w_q_illegal = (mon.Q > 4'd9);

`ifdef BCD_MON_CO_CHECK_EN
    logic w_exp_co;
    assign w_exp_co = mon.ENABLE & ~mon.LOAD &
                      ((mon.UP & (mon.Q == 4'd9)) | (~mon.UP & (mon.Q == 4'd0)));
    assign w_co_mismatch = (mon.CO != w_exp_co);
`else
    assign w_co_mismatch = 1'b0;
`endif

    assign w_fault = ~w_q_match | w_q_illegal | w_co_mismatch;

    // Prediction always starts from the observed digit, so one bad sample costs one fault.
    always_comb begin
        w_exp_q_next    = mon.Q;
        w_exp_wrap_next = 1'b0;
        if (mon.LOAD) begin
            w_exp_q_next = mon.D;
        end else if (!mon.ENABLE) begin
            w_exp_q_next = mon.Q;
        end else if (mon.UP) begin
            if (mon.Q == 4'd9) begin
                w_exp_q_next    = 4'd0;
                w_exp_wrap_next = 1'b1;
            end else begin
                w_exp_q_next = mon.Q + 4'd1;
            end
        end else begin
            if (mon.Q == 4'd0) begin
                w_exp_q_next    = 4'd9;
                w_exp_wrap_next = 1'b1;
            end else begin
                w_exp_q_next = mon.Q - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_err_pulse_next = 1'b0;
        w_illegal_next   = 1'b0;
        w_co_err_next    = 1'b0;
        w_err_next       = r_err;
        w_err_cnt_next   = r_err_cnt;
        w_wrap_cnt_next  = r_wrap_cnt;
        unique case (r_state)
            StSync: begin
                w_state_next = StTrack;
            end
            StTrack: begin
                w_illegal_next = w_q_illegal;
                w_co_err_next  = w_co_mismatch;
                if (w_fault) begin
                    w_err_pulse_next = 1'b1;
                    w_err_next       = 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        w_err_cnt_next = r_err_cnt + 8'd1;
                    end
                    w_state_next = StFault;
                end else if (r_exp_wrap) begin
                    w_wrap_cnt_next = r_wrap_cnt + 8'd1;
                end
            end
            StFault: begin
                w_illegal_next = w_q_illegal;
                w_co_err_next  = w_co_mismatch;
                if (!w_fault) begin
                    w_state_next = StTrack;
                end
            end
            default: begin
                w_state_next = StSync;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state     <= StSync;
            r_exp_q     <= 4'd0;
            r_exp_wrap  <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err       <= 1'b0;
            r_illegal   <= 1'b0;
            r_co_err    <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_wrap_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_exp_q     <= w_exp_q_next;
            r_exp_wrap  <= w_exp_wrap_next;
            r_err_pulse <= w_err_pulse_next;
            r_err       <= w_err_next;
            r_illegal   <= w_illegal_next;
            r_co_err    <= w_co_err_next;
            r_err_cnt   <= w_err_cnt_next;
            r_wrap_cnt  <= w_wrap_cnt_next;
        end
    end

    assign mon.STATE     = r_state;
    assign mon.EXP_Q     = r_exp_q;
    assign mon.ERR_PULSE = r_err_pulse;
    assign mon.ERR       = r_err;
    assign mon.ILLEGAL   = r_illegal;
    assign mon.CO_ERR    = r_co_err;
    assign mon.ERR_CNT   = r_err_cnt;
    assign mon.WRAP_CNT  = r_wrap_cnt;

endmodule

// File: tb/tb_bcd_counter_monitor.sv
// Directed bench for bcd_counter_monitor: a behavioural BCD counter feeds the monitor,
// with occasional forced Q/CO values; expected monitor outputs are hand-computed.
module tb_bcd_counter_monitor;

    logic CLK;
    logic CLR;
    int   n_tests;
    int   n_fail;
    logic [3:0] cnt;
    logic [3:0] down_seq [4];

    bcd_counter_monitor_if mon ();

    bcd_counter_monitor dut (
        .CLK (CLK),
        .CLR (CLR),
        .mon (mon)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference counter behaviour used only to generate stimulus.
    function automatic logic [3:0] model_next(input logic [3:0] q);
        if (mon.LOAD) return mon.D;
        if (!mon.ENABLE) return q;
        if (mon.UP) return (q == 4'd9) ? 4'd0 : q + 4'd1;
        return (q == 4'd0) ? 4'd9 : q - 4'd1;
    endfunction

    function automatic logic model_co(input logic [3:0] q);
        return mon.ENABLE & ~mon.LOAD & ((mon.UP & (q == 4'd9)) | (~mon.UP & (q == 4'd0)));
    endfunction

    task automatic apply(input logic [3:0] q, input logic co);
        mon.Q  = q;
        mon.CO = co;
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc();
        logic [3:0] nxt;
        nxt = model_next(cnt);
        apply(cnt, model_co(cnt));
        cnt = nxt;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        down_seq[0] = 4'd1;
        down_seq[1] = 4'd0;
        down_seq[2] = 4'd9;
        down_seq[3] = 4'd8;
        CLR = 1'b0;
        mon.D = 4'd0;
        mon.LOAD = 1'b0;
        mon.ENABLE = 1'b0;
        mon.UP = 1'b0;
        mon.Q = 4'd0;
        mon.CO = 1'b0;
        cnt = 4'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_state", mon.STATE, 0);
        chk("rst_exp_q", mon.EXP_Q, 0);
        chk("rst_err", mon.ERR, 0);
        chk("rst_err_pulse", mon.ERR_PULSE, 0);
        chk("rst_illegal", mon.ILLEGAL, 0);
        chk("rst_co_err", mon.CO_ERR, 0);
        chk("rst_err_cnt", mon.ERR_CNT, 0);
        chk("rst_wrap_cnt", mon.WRAP_CNT, 0);

        // Up-count for 25 cycles from 0.
        CLR = 1'b1;
        mon.ENABLE = 1'b1;
        mon.UP = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            cyc();
            if (i == 1) chk("sync_to_track", mon.STATE, 1);
            chk("up_exp_q", mon.EXP_Q, i % 10);
        end
        chk("up_wrap_cnt", mon.WRAP_CNT, 2);
        chk("up_err", mon.ERR, 0);
        chk("up_err_cnt", mon.ERR_CNT, 0);

        // Step down to 4, then hold.
        mon.UP = 1'b0;
        cyc();
        mon.ENABLE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_exp_q", mon.EXP_Q, 4);
        end
        chk("hold_err", mon.ERR, 0);
        chk("hold_state", mon.STATE, 1);

        // Down-count through 0 -> 9.
        mon.ENABLE = 1'b1;
        cyc();
        cyc();
        chk("down_start_exp_q", mon.EXP_Q, 2);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("down_exp_q", mon.EXP_Q, down_seq[i]);
        end
        chk("down_wrap_cnt", mon.WRAP_CNT, 3);
        chk("down_err", mon.ERR, 0);
        chk("down_co_err", mon.CO_ERR, 0);

        // Load 5 mid down-count.
        mon.LOAD = 1'b1;
        mon.D = 4'd5;
        cyc();
        mon.LOAD = 1'b0;
        chk("load5_exp_q", mon.EXP_Q, 5);
        cyc();
        chk("load5_next_exp_q", mon.EXP_Q, 4);
        chk("load5_wrap_cnt", mon.WRAP_CNT, 3);
        chk("load5_err", mon.ERR, 0);

        // Load 12: counter then shows an illegal digit that matches the prediction.
        mon.LOAD = 1'b1;
        mon.D = 4'd12;
        cyc();
        chk("load12_exp_q", mon.EXP_Q, 12);
        chk("load12_illegal_early", mon.ILLEGAL, 0);
        mon.D = 4'd3;
        cyc();
        chk("illegal_flag", mon.ILLEGAL, 1);
        chk("illegal_pulse", mon.ERR_PULSE, 1);
        chk("illegal_err", mon.ERR, 1);
        chk("illegal_err_cnt", mon.ERR_CNT, 1);
        chk("illegal_state", mon.STATE, 2);
        chk("illegal_reload_exp", mon.EXP_Q, 3);
        mon.LOAD = 1'b0;
        cyc();
        chk("illegal_clear", mon.ILLEGAL, 0);
        chk("illegal_pulse_clear", mon.ERR_PULSE, 0);
        chk("illegal_back_track", mon.STATE, 1);
        chk("illegal_err_sticky", mon.ERR, 1);
        chk("illegal_after_exp", mon.EXP_Q, 2);

        // Force Q=7 where 3 is expected, a second mismatch in FAULT, then resync.
        mon.UP = 1'b1;
        cyc();
        apply(4'd7, 1'b0);
        chk("force_pulse", mon.ERR_PULSE, 1);
        chk("force_err_cnt", mon.ERR_CNT, 2);
        chk("force_state", mon.STATE, 2);
        chk("force_exp_q", mon.EXP_Q, 8);
        apply(4'd1, 1'b0);
        chk("fault_no_pulse", mon.ERR_PULSE, 0);
        chk("fault_err_cnt", mon.ERR_CNT, 2);
        chk("fault_state", mon.STATE, 2);
        chk("fault_exp_q", mon.EXP_Q, 2);
        cnt = 4'd2;
        cyc();
        chk("resync_state", mon.STATE, 1);
        chk("resync_exp_q", mon.EXP_Q, 3);
        chk("resync_pulse", mon.ERR_PULSE, 0);

        // Hold CO low at Q=9 while up-counting.
        repeat (6) cyc();
        chk("pre_co_exp_q", mon.EXP_Q, 9);
        apply(4'd9, 1'b0);
        cnt = 4'd0;
`ifdef BCD_MON_CO_CHECK_EN
        chk("co_err", mon.CO_ERR, 1);
        chk("co_pulse", mon.ERR_PULSE, 1);
        chk("co_err_cnt", mon.ERR_CNT, 3);
        chk("co_state", mon.STATE, 2);
`else
        chk("co_err_off", mon.CO_ERR, 0);
        chk("co_pulse_off", mon.ERR_PULSE, 0);
        chk("co_err_cnt_off", mon.ERR_CNT, 2);
        chk("co_state_off", mon.STATE, 1);
`endif
        cyc();
        chk("co_after_state", mon.STATE, 1);
        chk("co_after_co_err", mon.CO_ERR, 0);
`ifdef BCD_MON_CO_CHECK_EN
        chk("co_after_wrap", mon.WRAP_CNT, 3);
`else
        chk("co_after_wrap_off", mon.WRAP_CNT, 4);
`endif

        // Mid-count CLR pulse, including an edge with an illegal Q while held in reset.
        CLR = 1'b0;
        #2;
        chk("clr_state", mon.STATE, 0);
        chk("clr_exp_q", mon.EXP_Q, 0);
        chk("clr_err", mon.ERR, 0);
        chk("clr_err_cnt", mon.ERR_CNT, 0);
        chk("clr_wrap_cnt", mon.WRAP_CNT, 0);
        apply(4'd15, 1'b0);
        chk("clr_edge_pulse", mon.ERR_PULSE, 0);
        chk("clr_edge_illegal", mon.ILLEGAL, 0);
        chk("clr_edge_state", mon.STATE, 0);
        CLR = 1'b1;
        cnt = 4'd5;
        cyc();
        chk("resume_state", mon.STATE, 1);
        chk("resume_exp_q", mon.EXP_Q, 6);
        chk("resume_err", mon.ERR, 0);
        cyc();
        chk("resume_err_cnt", mon.ERR_CNT, 0);
        chk("resume_exp_q2", mon.EXP_Q, 7);

        // Error-count saturation: 260 separate faults.
        mon.ENABLE = 1'b0;
        for (int i = 0; i < 260; i++) begin
            logic [3:0] v;
            v = i[0] ? 4'd1 : 4'd2;
            apply(v, 1'b0);
            apply(v, 1'b0);
        end
        chk("sat_err_cnt", mon.ERR_CNT, 255);
        chk("sat_state", mon.STATE, 1);
        chk("sat_err", mon.ERR, 1);
        chk("sat_exp_q", mon.EXP_Q, 1);

        // Loading 9 at Q=0 is not a wrap.
        mon.ENABLE = 1'b1;
        mon.UP = 1'b0;
        apply(4'd1, 1'b0);
        mon.LOAD = 1'b1;
        mon.D = 4'd9;
        apply(4'd0, 1'b0);
        chk("load9_exp_q", mon.EXP_Q, 9);
        mon.LOAD = 1'b0;
        apply(4'd9, 1'b0);
        chk("load9_wrap_cnt", mon.WRAP_CNT, 0);
        chk("load9_state", mon.STATE, 1);
        chk("load9_exp_next", mon.EXP_Q, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_monitor.md
BCD_COUNTER_MONITOR -- requirements
Module: bcd_counter_monitor

Interface
REQ-001 The module SHALL provide port CLK, input, 1, the single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL provide port CLR, input, 1, the reset: asynchronous, active-low, and shared with the monitored BCD counter.
REQ-003 The module SHALL provide inputs D[3:0], LOAD, ENABLE and UP (1 each), which are copies of the control inputs driven to the monitored counter.
REQ-004 The module SHALL provide inputs Q[3:0] and CO (1), which are the monitored counter's digit and carry outputs.
REQ-005 The module SHALL provide output ERR_PULSE, 1, high for exactly one cycle per newly detected fault.
REQ-006 The module SHALL provide output ERR, 1, a sticky fault flag.
REQ-007 The module SHALL provide output ILLEGAL, 1, high for one cycle when the sampled Q is greater than 9.
REQ-008 The module SHALL provide output CO_ERR, 1, high for one cycle on a carry mismatch.
REQ-009 The module SHALL provide output EXP_Q[3:0], the registered expected digit.
REQ-010 The module SHALL provide output ERR_CNT[7:0], the fault event count, which saturates at 255.
REQ-011 The module SHALL provide output WRAP_CNT[7:0], the count of verified digit wraps, modulo 256.
REQ-012 The module SHALL provide output STATE[1:0], encoded SYNC=00, TRACK=01, FAULT=10.

Function
REQ-013 At each rising edge the module SHALL sample Q, CO and the control inputs as they were just before that edge.
REQ-014 The next-expected rule SHALL be evaluated in this priority order:
- LOAD=1 -> D, loaded as-is, including values above 9.
- else ENABLE=0 -> Q unchanged.
- else UP=1 -> Q+1, with 9 wrapping to 0.
- else -> Q-1, with 0 wrapping to 9.
REQ-015 The expected carry SHALL be ENABLE & ~LOAD & ((UP & Q==9) | (~UP & Q==0)), computed from the sampled values.
REQ-016 In SYNC the module SHALL:
- perform no compare;
- load EXP_Q from the next-expected rule applied to the sampled Q;
- go to TRACK on the first edge after reset release.
REQ-017 In TRACK the module SHALL compare the sampled Q against EXP_Q.
- On a match it stays in TRACK.
- On a mismatch or an ILLEGAL condition it asserts ERR_PULSE, sets ERR, increments ERR_CNT (saturating) and goes to FAULT.
REQ-018 In FAULT, further mismatches SHALL NOT pulse ERR_PULSE or increment ERR_CNT; the first matching sample returns the state to TRACK.
REQ-019 In TRACK and FAULT, EXP_Q SHALL be recomputed every cycle from the observed Q, not from the old EXP_Q, so the monitor resynchronises after a single fault.
REQ-020 ILLEGAL SHALL be asserted for any sampled Q in the range 10..15, independent of state except SYNC, even when Q equals EXP_Q because D was loaded above 9.
REQ-021 WRAP_CNT SHALL increment when a matched sample in TRACK is the result of a 9->0 up-count or a 0->9 down-count; a load of 0 or 9 does not count as a wrap.
REQ-022 All flag outputs SHALL be registered, with one cycle of latency from the sampling edge.
REQ-023 LOAD=1 with ENABLE=1 SHALL follow the LOAD rule and expect CO=0.

Reset
REQ-024 When CLR=0 the module SHALL immediately set STATE=SYNC, EXP_Q=0, ERR_CNT=0, WRAP_CNT=0 and ERR=ERR_PULSE=ILLEGAL=CO_ERR=0.
REQ-025 A CLR assertion mid-operation SHALL discard the pending compare, with no ERR_PULSE generated for that cycle.
REQ-026 After CLR rises, the module SHALL resume in SYNC on the next rising edge.

Configuration
REQ-027 With macro BCD_MON_CO_CHECK_EN defined, the module SHALL compare CO against the expected carry in TRACK and FAULT.
- A mismatch pulses CO_ERR.
- A CO mismatch is treated as a fault event per REQ-017/018.
REQ-028 With BCD_MON_CO_CHECK_EN undefined, the module SHALL ignore CO and tie CO_ERR to 0.

Verification
REQ-029 Scenario: reset; ENABLE=1, UP=1 for 25 cycles from Q=0 -> no ERR; WRAP_CNT=2; EXP_Q tracks the sequence 0..9,0..
REQ-030 Scenario: ENABLE=0 for 10 cycles at Q=4 -> EXP_Q holds 4; no ERR.
REQ-031 Scenario: UP=0 from Q=2 for 4 cycles -> expected sequence 2,1,0,9,8; WRAP_CNT increments once; CO=1 only at Q=0.
REQ-032 Scenario: LOAD=1 with D=5 for one cycle during a down-count -> next Q=5 matches; no wrap counted. Repeat with D=12 -> ILLEGAL pulses and ERR=1.
REQ-033 Scenario: force Q=7 where 3 is expected, then resume a correct count -> one ERR_PULSE; ERR_CNT=1; STATE goes TRACK->FAULT->TRACK.
REQ-034 Scenario, with BCD_MON_CO_CHECK_EN defined: hold CO=0 at Q=9 with UP=1 -> CO_ERR and ERR_PULSE for one cycle. Rebuilt with the macro undefined -> no error; then pulse CLR low mid-count -> all outputs 0 and STATE=SYNC.
